// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
// Imported by the write-port arbiter and the address decoder.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_P    = 2'd1,
    GRANT_M    = 2'd2
  } grant_e;

endpackage

// File: rtl/decoder5to32.sv
// Existing 5-to-32 one-hot address decoder shared by register-file logic.
// Purely combinational: exactly one output bit is set for every address.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  output logic [REG_COUNT-1:0]  o_dec
);

  always_comb begin
    o_dec = '0;
    o_dec[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and the
// multicycle unit, registers the winner and drives the one-hot write enables.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [REG_ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_data,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [REG_ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0]     m_data,
  output logic                  rf_wvalid,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [REG_COUNT-1:0]  rf_we,
  output logic [15:0]           stall_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0]   r_starve;
  logic                  r_wvalid;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [15:0]           r_stall;

  grant_e                w_grant;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]     w_data;
  logic                  w_stall;
  logic [REG_COUNT-1:0]  w_dec;

  // Pipeline wins by default; a starved multicycle request takes the cycle.
  always_comb begin
    w_grant = GRANT_NONE;
    if (!rst) begin
      if (m_valid && (!p_valid || (r_starve == STARVE_LIM))) begin
        w_grant = GRANT_M;
      end else if (p_valid) begin
        w_grant = GRANT_P;
      end
    end
  end

  assign p_ready = (w_grant == GRANT_P);
  assign m_ready = (w_grant == GRANT_M);
  assign w_addr  = m_ready ? m_addr : p_addr;
  assign w_data  = m_ready ? m_data : p_data;
  assign w_stall = (p_valid && !p_ready) || (m_valid && !m_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= '0;
    end else begin
      r_starve <= (m_valid && !m_ready) ? r_starve + 1'b1 : '0;
      if (w_stall && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  // Address and data hold across idle cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_wvalid <= p_ready || m_ready;
      if (p_ready || m_ready) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end
  end

  decoder5to32 u_dec (
    .i_addr (r_waddr),
    .o_dec  (w_dec)
  );

  assign rf_wvalid = r_wvalid;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign rf_we     = w_dec & {REG_COUNT{r_wvalid && (r_waddr != REG_ZERO)}};
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the write port.
module tb_regfile_wr_arbiter;

  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              p_valid = 1'b0;
  logic              p_ready;
  logic [4:0]        p_addr = '0;
  logic [DATA_W-1:0] p_data = '0;
  logic              m_valid = 1'b0;
  logic              m_ready;
  logic [4:0]        m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              rf_wvalid;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       rf_we;
  logic [15:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: what the register-file port should show, plus fairness state.
  logic              expWvalid;
  logic [4:0]        expWaddr;
  logic [DATA_W-1:0] expWdata;
  logic [15:0]       expStall;
  int                mWait;
  logic              expPGrant;
  logic              expMGrant;

  regfile_wr_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .rf_wvalid (rf_wvalid),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_we     (rf_we),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    expWvalid = 1'b0;
    expWaddr  = '0;
    expWdata  = '0;
    expStall  = '0;
    mWait     = 0;
  endtask

  // The multicycle side wins once it has lost STARVE_MAX cycles in a row.
  task automatic computeGrants();
    expMGrant = m_valid && (!p_valid || (mWait == STARVE_MAX));
    expPGrant = p_valid && !expMGrant;
  endtask

  task automatic advanceModel();
    if ((p_valid && !expPGrant) || (m_valid && !expMGrant)) begin
      if (expStall != 16'hFFFF) expStall = expStall + 16'd1;
    end
    mWait = (m_valid && !expMGrant) ? mWait + 1 : 0;
    if (expPGrant) begin
      expWvalid = 1'b1; expWaddr = p_addr; expWdata = p_data;
    end else if (expMGrant) begin
      expWvalid = 1'b1; expWaddr = m_addr; expWdata = m_data;
    end else begin
      expWvalid = 1'b0;
    end
  endtask

  function automatic logic [31:0] expWe();
    return (expWvalid && expWaddr != 5'd0) ? (32'h1 << expWaddr) : 32'h0;
  endfunction

  task automatic idleCycle();
    p_valid = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    computeGrants();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    p_valid = 1'b1;
    m_valid = 1'b1;
    p_addr  = 5'd3;
    m_addr  = 5'd4;
    rst     = 1'b1;
    modelReset();
    #3;
    checks++;
    if ({rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got wvalid=%0b waddr=%0d wdata=%0h we=%0h stall=%0d, expected all zero",
               rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt);
    end
    checks++;
    if ({p_ready, m_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready: got p_ready=%0b m_ready=%0b, expected 0 0", p_ready, m_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycle();
  endtask

  task automatic test_single_write();
    p_valid = 1'b1;
    p_addr  = 5'd7;
    p_data  = 32'hDEADBEEF;
    @(negedge clk);
    computeGrants();
    checks++;
    if ({p_ready, m_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL single_ready: got p=%0b m=%0b, expected p=1 m=0", p_ready, m_ready);
    end
    advanceModel();
    @(posedge clk);
    #1;
    p_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 32'h00000080 || rf_wdata !== 32'hDEADBEEF || rf_wvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_write: got we=%0h wdata=%0h wvalid=%0b, expected we=80 wdata=deadbeef wvalid=1",
               rf_we, rf_wdata, rf_wvalid);
    end
    computeGrants();
    advanceModel();
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (rf_we !== 32'h0 || rf_wvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got we=%0h wvalid=%0b, expected we=0 wvalid=0", rf_we, rf_wvalid);
    end
    computeGrants();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  // Both requesters held; grant order must be p,p,p,m from a clean start.
  task automatic test_contention(input int cycles);
    idleCycle();
    for (int i = 0; i < cycles; i++) begin
      p_valid = 1'b1; p_addr = 5'd1 + 5'(i % 8); p_data = $urandom;
      m_valid = 1'b1; m_addr = 5'd20 + 5'(i % 8); m_data = $urandom;
      @(negedge clk);
      computeGrants();
      checks++;
      if ({p_ready, m_ready} !== ((i % (STARVE_MAX + 1) == STARVE_MAX) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL contention_grant[%0d]: got p=%0b m=%0b, expected m_win=%0b",
                 i, p_ready, m_ready, (i % (STARVE_MAX + 1) == STARVE_MAX));
      end
      checks++;
      if ({rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt} !== {expWvalid, expWaddr, expWdata, expWe(), expStall}) begin
        errors++;
        $display("[TB] FAIL contention_out[%0d]: got wv=%0b a=%0d d=%0h we=%0h st=%0d, expected wv=%0b a=%0d d=%0h we=%0h st=%0d",
                 i, rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt, expWvalid, expWaddr, expWdata, expWe(), expStall);
      end
      advanceModel();
      @(posedge clk);
      #1;
    end
    idleCycle();
  endtask

  task automatic test_m_only();
    m_valid = 1'b1;
    m_addr  = 5'd31;
    m_data  = 32'hCAFEF00D;
    @(negedge clk);
    computeGrants();
    checks++;
    if ({p_ready, m_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL m_only_ready: got p=%0b m=%0b, expected p=0 m=1", p_ready, m_ready);
    end
    advanceModel();
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 32'h80000000 || rf_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL m_only_write: got we=%0h wdata=%0h, expected we=80000000 wdata=cafef00d", rf_we, rf_wdata);
    end
    computeGrants();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_addr();
    p_valid = 1'b1;
    p_addr  = 5'd0;
    p_data  = 32'h12345678;
    @(negedge clk);
    computeGrants();
    checks++;
    if (p_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_ready: got p_ready=%0b, expected 1", p_ready);
    end
    advanceModel();
    @(posedge clk);
    #1;
    p_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_wvalid !== 1'b1 || rf_waddr !== 5'd0 || rf_we !== 32'h0 || rf_wdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL zero_write: got wv=%0b a=%0d we=%0h d=%0h, expected wv=1 a=0 we=0 d=12345678",
               rf_wvalid, rf_waddr, rf_we, rf_wdata);
    end
    computeGrants();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  // Five pipeline writes; reset lands mid-cycle while the third is presented.
  task automatic test_reset_midstream();
    for (int k = 0; k < 5; k++) begin
      p_valid = 1'b1;
      p_addr  = 5'd10 + 5'(k);
      p_data  = 32'hA0000000 + k;
      if (k == 2) begin
        checks++;
        if (rf_we !== (32'h1 << 11)) begin
          errors++;
          $display("[TB] FAIL midrst_prior: got we=%0h, expected %0h", rf_we, 32'h1 << 11);
        end
        #2 rst = 1'b1;
        modelReset();
        #1;
        checks++;
        if (rf_we !== 32'h0 || rf_wvalid !== 1'b0 || stall_cnt !== 16'd0 || p_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL midrst_drop: got we=%0h wv=%0b st=%0d p_ready=%0b, expected all 0",
                   rf_we, rf_wvalid, stall_cnt, p_ready);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        continue;
      end
      @(negedge clk);
      computeGrants();
      checks++;
      if ({p_ready, m_ready} !== {expPGrant, expMGrant}) begin
        errors++;
        $display("[TB] FAIL midrst_ready[%0d]: got p=%0b m=%0b, expected p=%0b m=%0b",
                 k, p_ready, m_ready, expPGrant, expMGrant);
      end
      checks++;
      if ({rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt} !== {expWvalid, expWaddr, expWdata, expWe(), expStall}) begin
        errors++;
        $display("[TB] FAIL midrst_out[%0d]: got wv=%0b a=%0d d=%0h we=%0h st=%0d, expected wv=%0b a=%0d d=%0h we=%0h st=%0d",
                 k, rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt, expWvalid, expWaddr, expWdata, expWe(), expStall);
      end
      advanceModel();
      @(posedge clk);
      #1;
    end
    idleCycle();
    checks++;
    if (rf_waddr !== 5'd14 || stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_after: got waddr=%0d stall=%0d, expected waddr=14 stall=0", rf_waddr, stall_cnt);
    end
  endtask

  // Random traffic; a loser keeps valid, addr and data stable until granted.
  task automatic test_random(input int cycles);
    logic pHold;
    logic mHold;
    pHold = 1'b0;
    mHold = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (!pHold) begin
        p_valid = ($urandom_range(0, 3) != 0);
        p_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        p_data  = $urandom;
      end
      if (!mHold) begin
        m_valid = ($urandom_range(0, 1) != 0);
        m_addr  = 5'($urandom);
        m_data  = $urandom;
      end
      @(negedge clk);
      computeGrants();
      checks++;
      if ({p_ready, m_ready} !== {expPGrant, expMGrant}) begin
        errors++;
        $display("[TB] FAIL random_ready[%0d]: got p=%0b m=%0b, expected p=%0b m=%0b",
                 i, p_ready, m_ready, expPGrant, expMGrant);
      end
      checks++;
      if ({rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt} !== {expWvalid, expWaddr, expWdata, expWe(), expStall}) begin
        errors++;
        $display("[TB] FAIL random_out[%0d]: got wv=%0b a=%0d d=%0h we=%0h st=%0d, expected wv=%0b a=%0d d=%0h we=%0h st=%0d",
                 i, rf_wvalid, rf_waddr, rf_wdata, rf_we, stall_cnt, expWvalid, expWaddr, expWdata, expWe(), expStall);
      end
      pHold = p_valid && !expPGrant;
      mHold = m_valid && !expMGrant;
      advanceModel();
      @(posedge clk);
      #1;
    end
    idleCycle();
  endtask

  task automatic test_saturation();
    test_contention(70000);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL saturation: got stall=%0h, expected ffff", stall_cnt);
    end
  endtask

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_contention(16);
    test_m_only();
    test_contention(8);
    test_zero_addr();
    test_reset_midstream();
    test_random(400);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
